// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell is reused LSB first over WIDTH
// cycles, with a start/busy/done handshake and a result register that only updates on completion.

module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum_s;
    logic             fa_carry_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] acc_shift_s;

    fa_cell u_fa (
        .a_i (sh_a_q[0]),
        .b_i (sh_b_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum_s),
        .c_o (fa_carry_s)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign acc_shift_s = (acc_q >> 1) | (WIDTH'(fa_sum_s) << (WIDTH - 1));
    assign last_bit_s  = (cnt_q == CW'(WIDTH - 1));

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_a_d  = a;
                    sh_b_d  = b;
                    carry_d = cin;
                    cnt_d   = {CW{1'b0}};
                    acc_d   = {WIDTH{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                acc_d   = acc_shift_s;
                carry_d = fa_carry_s;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit_s) begin
                    sum_d   = acc_shift_s;
                    cout_d  = fa_carry_s;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_a_q  <= {WIDTH{1'b0}};
            sh_b_q  <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: directed vectors and corner sequences on WIDTH=8, then a
// continuous-start random run on WIDTH=1, 8 and 32 against an arithmetic model.

module tb_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cin;
    logic [31:0] a_v;
    logic [31:0] b_v;

    logic        busy1, done1, cout1;
    logic [0:0]  sum1;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic        busy32, done32, cout32;
    logic [31:0] sum32;

    int n_pass  = 0;
    int n_total = 0;
    int edge_n  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a_v[0:0]), .b(b_v[0:0]), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));
    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a_v[7:0]), .b(b_v[7:0]), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
    serial_adder_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .a(a_v), .b(b_v), .cin(cin),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32));

    logic [32:0] res_s [3];
    logic [2:0]  busy_s;
    logic [2:0]  done_s;
    assign res_s[0] = {31'd0, cout1, sum1};
    assign res_s[1] = {24'd0, cout8, sum8};
    assign res_s[2] = {cout32, sum32};
    assign busy_s   = {busy32, busy8, busy1};
    assign done_s   = {done32, done8, done1};

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One WIDTH=8 operation: check latency, busy length, result and single-cycle done.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                          input logic [7:0] es, input logic ec, input string name);
        int lat;
        int busy_n;
        @(negedge clk);
        a_v = {24'd0, xa}; b_v = {24'd0, xb}; cin = xc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a_v = 32'hDEAD_BEEF; b_v = 32'h1234_5678; cin = 1'b1;
        lat = 0; busy_n = 0;
        while (!done8 && lat < 20) begin
            if (busy8) busy_n++;
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'd8);
        chk({name, " busy_cycles"}, 64'(busy_n), 64'd8);
        chk({name, " result"}, {55'd0, cout8, sum8}, {55'd0, ec, es});
        chk({name, " busy_at_done"}, {63'd0, busy8}, 64'd0);
        @(negedge clk);
        chk({name, " done_pulse"}, {63'd0, done8}, 64'd0);
    endtask

    vec_t vecs [7];

    initial begin
        int          lat;
        int          seen_done;
        int          e0;
        int          wd [3];
        int          ops [3];
        logic [32:0] exp_r [3];
        logic [31:0] cur_a, cur_b;
        logic        cur_c;

        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        wd[0] = 1; wd[1] = 8; wd[2] = 32;

        rst = 1'b1; start = 1'b0; cin = 1'b0; a_v = 32'd0; b_v = 32'd0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_state", {52'd0, busy8, done8, cout8, sum8, busy1, busy32}, 64'd0);
        end

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, $sformatf("vec%0d", i));

        // Second start during RUN must be ignored; old result held until done.
        @(negedge clk);
        a_v = 32'h3C; b_v = 32'h0F; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        a_v = 32'hFF; b_v = 32'hFF; cin = 1'b1; start = 1'b1;
        chk("ignore_start sum_held", {56'd0, sum8}, 64'h80);
        @(negedge clk); start = 1'b0;
        lat = 4;
        while (!done8 && lat < 20) begin
            chk("ignore_start no_partial", {55'd0, cout8, sum8}, 64'h080);
            @(negedge clk);
            lat++;
        end
        chk("ignore_start latency", 64'(lat), 64'd8);
        chk("ignore_start result", {55'd0, cout8, sum8}, 64'h04B);
        @(negedge clk); @(negedge clk);
        chk("ignore_start no_requeue", {62'd0, busy8, done8}, 64'd0);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        a_v = 32'h11; b_v = 32'h22; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort state", {54'd0, busy8, done8, cout8, sum8}, 64'd0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) seen_done++;
        end
        chk("abort no_done", 64'(seen_done), 64'd0);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_abort");

        // Continuous start, random operands, all three widths.
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cur_a = $urandom; cur_b = $urandom; cur_c = 1'($urandom_range(0, 1));
        a_v = cur_a; b_v = cur_b; cin = cur_c; start = 1'b1;
        e0 = edge_n + 1;
        for (int i = 0; i < 3; i++) begin ops[i] = 0; exp_r[i] = 33'd0; end
        for (int c = 0; c < 6900; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                int          p;
                int          rel;
                logic [32:0] m;
                p   = wd[i] + 2;
                rel = (edge_n - e0) % p;
                m   = (33'd1 << wd[i]) - 33'd1;
                if (rel == 0)
                    exp_r[i] = ({1'b0, cur_a} & m) + ({1'b0, cur_b} & m) + {32'd0, cur_c};
                chk($sformatf("w%0d busy", wd[i]), {63'd0, busy_s[i]}, {63'd0, rel < wd[i]});
                chk($sformatf("w%0d done", wd[i]), {63'd0, done_s[i]}, {63'd0, rel == wd[i]});
                if (rel == wd[i]) begin
                    chk($sformatf("w%0d result", wd[i]), {31'd0, res_s[i]}, {31'd0, exp_r[i]});
                    ops[i]++;
                end
            end
            cur_a = $urandom; cur_b = $urandom; cur_c = 1'($urandom_range(0, 1));
            a_v = cur_a; b_v = cur_b; cin = cur_c;
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++)
            chk($sformatf("w%0d ops_ge_200", wd[i]), {63'd0, ops[i] >= 200}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
